// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state enumeration and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR
  } lsu_state_e;

  // Size 2'b11 is an alias of word, so the word check keys off bit 1 only.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (size == SZ_HALF) return offset[0];
    if (size[1])         return |offset;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the pipeline request side and the DataMemory side of the LSU.
interface lsu_req_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misalign;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  rdata, done, misalign, busy
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output rdata, done, misalign, busy
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readData;
  logic        mem_stall;

  modport master (
    output mem_address, mem_writeData, mem_read, mem_write,
    input  mem_readData, mem_stall
  );
  modport slave (
    input  mem_address, mem_writeData, mem_read, mem_write,
    output mem_readData, mem_stall
  );
endinterface

// File: rtl/load_store_unit_byte_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word
// and merges sub-word store data into a memory word.
module byte_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] shifted;

  // Big-endian mirrors the lane index: byte offset o sits at lane 3-o, half offset o at 2-o.
  always_comb begin
    shamt       = 5'd0;
    lane_mask   = 32'hFFFF_FFFF;
    load_data_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        shamt     = {(BIG_ENDIAN ? ~offset_i : offset_i), 3'b000};
        lane_mask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt     = {(BIG_ENDIAN ? ~offset_i[1] : offset_i[1]), 4'b0000};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase

    shifted = rword_i >> shamt;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase

    merged_o = (rword_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns loads, performs read-modify-write for
// sub-word stores and rejects misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  byte_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (addr_q[1:0]),
    .rword_i     (mem.mem_readData),
    .wdata_i     (wdata_q),
    .load_data_o (lane_load),
    .merged_o    (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merged_q   <= 32'h0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // The store/load direction is carried by the state itself, so it is not kept separately.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          size_d  = req.req_size;
          uns_d   = req.req_unsigned;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          if (is_misaligned(req.req_size, req.req_addr[1:0])) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else if (!req.req_write) begin
            state_d = LOAD;
          end else if (req.req_size[1]) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        if (!mem.mem_stall) begin
          rdata_d = lane_load;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      STORE, RMW_WR: begin
        if (!mem.mem_stall) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RMW_RD: begin
        if (!mem.mem_stall) begin
          merged_d = lane_merged;
          state_d  = RMW_WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_writeData = 32'h0;
    if (state_q == STORE)  mem.mem_writeData = wdata_q;
    if (state_q == RMW_WR) mem.mem_writeData = merged_q;
  end

  assign mem.mem_address = {addr_q[31:2], 2'b00};
  assign mem.mem_read    = (state_q == LOAD)  || (state_q == RMW_RD);
  assign mem.mem_write   = (state_q == STORE) || (state_q == RMW_WR);

  assign req.rdata    = rdata_q;
  assign req.done     = done_q;
  assign req.misalign = misalign_q;
  assign req.busy     = (state_q != IDLE) || req.req_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed big-endian reference memory plus a
// cycle timeline derived from the access latency rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_req_if reqIf ();
  lsu_mem_if memIf ();

  load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .req (reqIf),
    .mem (memIf)
  );

  logic [7:0]  refBytes [0:255];
  logic [31:0] memWords [0:63];
  logic [31:0] lastRdata;
  logic [31:0] gotRdata;
  int checks = 0;
  int errors = 0;

  assign memIf.mem_readData = memWords[memIf.mem_address[7:2]];

  always @(posedge clk) begin
    if (memIf.mem_write && !memIf.mem_stall)
      memWords[memIf.mem_address[7:2]] <= memIf.mem_writeData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    reqIf.req_valid    = valid;
    reqIf.req_write    = wr;
    reqIf.req_size     = sz;
    reqIf.req_unsigned = uns;
    reqIf.req_addr     = addr;
    reqIf.req_wdata    = wd;
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    if (sz == SZ_BYTE) return 1;
    if (sz == SZ_HALF) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refWord(input int w);
    return {refBytes[4*w], refBytes[4*w+1], refBytes[4*w+2], refBytes[4*w+3]};
  endfunction

  // Bytes are assembled most-significant first: lower address is the more significant byte.
  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    int n;
    logic [31:0] v;
    n = sizeBytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(refBytes[int'(addr[7:0]) + i]);
    if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = sizeBytes(sz);
    for (int i = 0; i < n; i++) refBytes[int'(addr[7:0]) + i] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic setWord(input logic [31:0] addr, input logic [31:0] v);
    for (int i = 0; i < 4; i++) refBytes[int'({addr[7:2], 2'b00}) + i] = 8'(v >> (8 * (3 - i)));
    memWords[addr[7:2]] = v;
  endtask

  // Entered just after a rising edge with the unit idle; leaves one cycle after done.
  task automatic runTxn(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int k1, input int k2, input bit noise,
                        output logic [31:0] rdOut);
    bit mis, sub, inFirst, inSecond, expRead, expWrite;
    int expDone;
    logic [31:0] expRdata, expWd;
    mis = ((sz == SZ_HALF) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
    sub = wr && !mis && !sz[1];
    expDone = mis ? 1 : (sub ? 3 + k1 + k2 : 2 + k1);
    expRdata = lastRdata;
    expWd = wd;
    if (!wr && !mis) expRdata = refLoad(addr, sz, uns);
    if (wr && !mis) begin
      refStore(addr, sz, wd);
      if (sub) expWd = refWord(int'(addr[7:2]));
    end
    rdOut = 32'h0;

    applyStimulus(1'b1, wr, sz, uns, addr, wd);
    memIf.mem_stall = 1'($urandom_range(0, 1));
    #1;
    checkFlag("busy_accept", reqIf.busy, 1'b1);

    for (int c = 1; c <= expDone + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 && noise && !mis)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom);
      else
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      inFirst  = !mis && (c <= 1 + k1);
      inSecond = sub && (c >= 2 + k1) && (c <= 2 + k1 + k2);
      expRead  = inFirst && (!wr || sub);
      expWrite = (inFirst && wr && !sub) || inSecond;
      if (inFirst)       memIf.mem_stall = (c <= k1);
      else if (inSecond) memIf.mem_stall = (c < 2 + k1 + k2);
      else               memIf.mem_stall = 1'($urandom_range(0, 1));
      #1;
      checkFlag("mem_read", memIf.mem_read, expRead);
      checkFlag("mem_write", memIf.mem_write, expWrite);
      if (expRead || expWrite) checkOutput("mem_address", memIf.mem_address, {addr[31:2], 2'b00});
      if (expWrite) checkOutput("mem_writeData", memIf.mem_writeData, expWd);
      checkFlag("done", reqIf.done, c == expDone);
      checkFlag("misalign", reqIf.misalign, (c == expDone) && mis);
      checkFlag("busy", reqIf.busy, (c < expDone) || reqIf.req_valid);
      if (c == expDone) begin
        rdOut = reqIf.rdata;
        checkOutput("rdata", reqIf.rdata, expRdata);
        checkOutput("mem_word", memWords[addr[7:2]], refWord(int'(addr[7:2])));
      end
    end
    lastRdata = expRdata;
  endtask

  initial begin
    rst = 1'b0;
    lastRdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    memIf.mem_stall = 1'b0;
    for (int w = 0; w < 64; w++) setWord(32'(w * 4), $urandom);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rdata", reqIf.rdata, 32'h0);
    checkFlag("rst_done", reqIf.done, 1'b0);
    checkFlag("rst_misalign", reqIf.misalign, 1'b0);
    checkFlag("rst_busy", reqIf.busy, 1'b0);
    checkOutput("rst_mem_address", memIf.mem_address, 32'h0);
    checkOutput("rst_mem_writeData", memIf.mem_writeData, 32'h0);
    checkFlag("rst_mem_read", memIf.mem_read, 1'b0);
    checkFlag("rst_mem_write", memIf.mem_write, 1'b0);
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    checkFlag("rst_busy_follows_valid", reqIf.busy, 1'b1);
    @(posedge clk);
    #1;
    checkFlag("rst_no_accept", memIf.mem_read, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed accesses");
    runTxn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0, 1'b0, gotRdata);
    checkOutput("sw_word", memWords[4], 32'hDEAD_BEEF);

    setWord(32'h10, 32'h1234_56F0);
    runTxn(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 0, 0, 1'b0, gotRdata);
    checkOutput("lb_value", gotRdata, 32'hFFFF_FFF0);
    runTxn(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 0, 0, 1'b0, gotRdata);
    checkOutput("lbu_value", gotRdata, 32'h0000_00F0);
    runTxn(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 3, 0, 1'b0, gotRdata);
    checkOutput("lb_stalled_value", gotRdata, 32'hFFFF_FFF0);

    setWord(32'h20, 32'h1122_3344);
    runTxn(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_ABCD, 0, 0, 1'b0, gotRdata);
    checkOutput("sh_word", memWords[8], 32'h1122_ABCD);

    runTxn(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 0, 0, 1'b0, gotRdata);
    runTxn(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 0, 0, 1'b1, gotRdata);
    checkOutput("lh_busy_value", gotRdata, 32'h0000_1122);

    $display("[TB] random accesses");
    for (int t = 0; t < 60; t++) begin
      runTxn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), gotRdata);
    end

    $display("[TB] reset during RMW write");
    setWord(32'h40, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000_0012);
    memIf.mem_stall = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    checkFlag("rmw_rd_read", memIf.mem_read, 1'b1);
    @(posedge clk);
    #1;
    memIf.mem_stall = 1'b1;
    #1;
    checkFlag("rmw_wr_write", memIf.mem_write, 1'b1);
    checkOutput("rmw_wr_data", memIf.mem_writeData, 32'hA512_A5A5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkFlag("midrst_mem_write", memIf.mem_write, 1'b0);
    checkFlag("midrst_mem_read", memIf.mem_read, 1'b0);
    checkFlag("midrst_busy", reqIf.busy, 1'b0);
    checkFlag("midrst_done", reqIf.done, 1'b0);
    checkFlag("midrst_misalign", reqIf.misalign, 1'b0);
    checkOutput("midrst_rdata", reqIf.rdata, 32'h0);
    checkOutput("midrst_mem_address", memIf.mem_address, 32'h0);
    checkOutput("midrst_word", memWords[16], 32'hA5A5_A5A5);
    rst = 1'b1;
    memIf.mem_stall = 1'b0;
    lastRdata = 32'h0;
    @(posedge clk);
    #1;
    checkFlag("postrst_done", reqIf.done, 1'b0);
    runTxn(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1, 0, 1'b0, gotRdata);
    checkOutput("postrst_lw", gotRdata, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
